// File: rtl/datapath.sv
// Five-stage-style MIPS subset datapath: fetch, decode, execute, memory/writeback.
// Control inputs are applied unpipelined to whichever stage consumes them.
module datapath #(
  parameter int DWIDTH       = 32,
  parameter int PC_WIDTH     = 32,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                    d_clk,
  input  logic                    d_rst,
  input  logic                    d_i_ce,
  input  logic                    d_i_RegDst,
  input  logic                    d_i_Branch,
  input  logic                    d_i_RegWrite,
  input  logic                    d_i_ALUSrc,
  input  logic                    d_i_MemRead,
  input  logic                    d_i_MemWrite,
  input  logic                    d_i_MemtoReg,
  output logic [PC_WIDTH-1:0]     fs_es_o_pc,
  output logic [DWIDTH-1:0]       write_back_data,
  output logic [OPCODE_WIDTH-1:0] ds_es_o_opcode
);

  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         fs_ds_o_instr;
  logic [DWIDTH-1:0]   ds_es_o_data_rs;
  logic [DWIDTH-1:0]   ds_es_o_data_rt;
  logic [DWIDTH-1:0]   ds_imm;
  logic [5:0]          ds_funct;
  logic [4:0]          ds_dest;
  logic [PC_WIDTH-1:0] ds_pc;
  logic [DWIDTH-1:0]   es_ms_alu_value;
  logic [DWIDTH-1:0]   es_rt;
  logic [4:0]          es_dest;

  logic [DWIDTH-1:0] rf   [32];
  logic [DWIDTH-1:0] dmem [64];

  logic [31:0]         imem_word;
  logic [DWIDTH-1:0]   rf_rs, rf_rt;
  logic [DWIDTH-1:0]   alu_b, alu_result, mem_data;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target, pc_next;

  always_comb begin
    imem_word = '0;
    if (pc[7:2] == 6'd0) imem_word = 32'h8CE6_0014;
  end

  assign rf_rs = (fs_ds_o_instr[25:21] == 5'd0) ? '0 : rf[fs_ds_o_instr[25:21]];
  assign rf_rt = (fs_ds_o_instr[20:16] == 5'd0) ? '0 : rf[fs_ds_o_instr[20:16]];

  assign alu_b = d_i_ALUSrc ? ds_imm : ds_es_o_data_rt;

  always_comb begin
    alu_result = ds_es_o_data_rs + alu_b;
    if (ds_es_o_opcode == OPCODE_WIDTH'(0)) begin
      case (ds_funct)
        6'h20:   alu_result = ds_es_o_data_rs + alu_b;
        6'h22:   alu_result = ds_es_o_data_rs - alu_b;
        6'h24:   alu_result = ds_es_o_data_rs & alu_b;
        6'h25:   alu_result = ds_es_o_data_rs | alu_b;
        6'h2A:   alu_result = ($signed(ds_es_o_data_rs) < $signed(alu_b)) ? DWIDTH'(1) : '0;
        default: alu_result = '0;
      endcase
    end else if (ds_es_o_opcode == OPCODE_WIDTH'(6'h04)) begin
      alu_result = ds_es_o_data_rs - alu_b;
    end
  end

  assign branch_taken  = d_i_Branch && (ds_es_o_data_rs == ds_es_o_data_rt);
  assign branch_target = ds_pc + PC_WIDTH'(4)
                       + ({{(PC_WIDTH-16){ds_imm[15]}}, ds_imm[15:0]} << 2);
  assign pc_next       = branch_taken ? branch_target : pc + PC_WIDTH'(4);

  assign mem_data        = d_i_MemRead ? dmem[es_ms_alu_value[7:2]] : '0;
  assign write_back_data = d_i_MemtoReg ? mem_data : es_ms_alu_value;

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      pc              <= '0;
      fs_es_o_pc      <= '0;
      fs_ds_o_instr   <= '0;
      ds_es_o_data_rs <= '0;
      ds_es_o_data_rt <= '0;
      ds_es_o_opcode  <= '0;
      ds_imm          <= '0;
      ds_funct        <= '0;
      ds_dest         <= '0;
      ds_pc           <= '0;
      es_ms_alu_value <= '0;
      es_rt           <= '0;
      es_dest         <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= DWIDTH'(4 * i);
      for (int unsigned i = 0; i < 64; i++) dmem[i] <= DWIDTH'(32'hA000_0000 | i);
    end else if (d_i_ce) begin
      fs_ds_o_instr   <= imem_word;
      fs_es_o_pc      <= pc;
      pc              <= pc_next;

      ds_es_o_data_rs <= rf_rs;
      ds_es_o_data_rt <= rf_rt;
      ds_es_o_opcode  <= OPCODE_WIDTH'(fs_ds_o_instr[31:26]);
      ds_imm          <= {{(DWIDTH-16){fs_ds_o_instr[15]}}, fs_ds_o_instr[15:0]};
      ds_funct        <= fs_ds_o_instr[5:0];
      ds_dest         <= d_i_RegDst ? fs_ds_o_instr[15:11] : fs_ds_o_instr[20:16];
      ds_pc           <= fs_es_o_pc;

      es_ms_alu_value <= alu_result;
      es_rt           <= ds_es_o_data_rt;
      es_dest         <= ds_dest;

      if (d_i_MemWrite) dmem[es_ms_alu_value[7:2]] <= es_rt;
      if (d_i_RegWrite && es_dest != 5'd0) rf[es_dest] <= write_back_data;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: reset contents, lw pipeline walk, nop run,
// clock-enable freeze/resume and asynchronous mid-run reset.
module tb_datapath;

  logic        d_clk = 1'b0;
  logic        d_rst;
  logic        d_i_ce, d_i_RegDst, d_i_Branch, d_i_RegWrite, d_i_ALUSrc;
  logic        d_i_MemRead, d_i_MemWrite, d_i_MemtoReg;
  logic [31:0] fs_es_o_pc;
  logic [31:0] write_back_data;
  logic [5:0]  ds_es_o_opcode;

  int n_checks = 0;
  int n_fail   = 0;

  datapath #(.DWIDTH(32), .PC_WIDTH(32), .OPCODE_WIDTH(6)) dut (
    .d_clk           (d_clk),
    .d_rst           (d_rst),
    .d_i_ce          (d_i_ce),
    .d_i_RegDst      (d_i_RegDst),
    .d_i_Branch      (d_i_Branch),
    .d_i_RegWrite    (d_i_RegWrite),
    .d_i_ALUSrc      (d_i_ALUSrc),
    .d_i_MemRead     (d_i_MemRead),
    .d_i_MemWrite    (d_i_MemWrite),
    .d_i_MemtoReg    (d_i_MemtoReg),
    .fs_es_o_pc      (fs_es_o_pc),
    .write_back_data (write_back_data),
    .ds_es_o_opcode  (ds_es_o_opcode)
  );

  always #5 d_clk = ~d_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge d_clk);
    #1;
  endtask

  initial begin
    d_rst        = 1'b0;
    d_i_ce       = 1'b1;
    d_i_RegDst   = 1'b0;
    d_i_Branch   = 1'b0;
    d_i_RegWrite = 1'b1;
    d_i_ALUSrc   = 1'b1;
    d_i_MemRead  = 1'b1;
    d_i_MemWrite = 1'b0;
    d_i_MemtoReg = 1'b1;

    repeat (2) step();
    check("rst_pc",     dut.pc, 32'h0);
    check("rst_fs_pc",  fs_es_o_pc, 32'h0);
    check("rst_instr",  dut.fs_ds_o_instr, 32'h0);
    check("rst_opcode", {26'h0, ds_es_o_opcode}, 32'h0);
    check("rst_alu",    dut.es_ms_alu_value, 32'h0);
    check("rst_rf7",    dut.rf[7], 32'h1C);
    d_rst = 1'b1;

    // lw $6,20($7): rf[7]=0x1C, addr 0x30 -> dmem[12]
    step();
    check("e1_instr", dut.fs_ds_o_instr, 32'h8CE6_0014);
    check("e1_fs_pc", fs_es_o_pc, 32'h0);
    step();
    check("e2_rs",     dut.ds_es_o_data_rs, 32'h1C);
    check("e2_rt",     dut.ds_es_o_data_rt, 32'h18);
    check("e2_opcode", {26'h0, ds_es_o_opcode}, 32'h23);
    step();
    check("e3_alu", dut.es_ms_alu_value, 32'h30);
    check("e3_wb",  write_back_data, 32'hA000_000C);
    step();
    check("e4_rf6", dut.rf[6], 32'hA000_000C);
    check("e4_pc",  dut.pc, 32'h10);

    for (int k = 5; k <= 11; k++) begin
      step();
      check($sformatf("nop_pc_e%0d", k), dut.pc, 32'(4 * k));
    end
    check("nop_fs_pc", fs_es_o_pc, 32'd40);
    check("nop_rf6",   dut.rf[6], 32'hA000_000C);
    check("nop_rf0",   dut.rf[0], 32'h0);
    check("nop_wb",    write_back_data, 32'hA000_0000);

    d_i_ce = 1'b0;
    repeat (3) step();
    check("frz_pc",    dut.pc, 32'd44);
    check("frz_fs_pc", fs_es_o_pc, 32'd40);
    check("frz_rf6",   dut.rf[6], 32'hA000_000C);
    d_i_ce = 1'b1;
    step();
    check("res_pc",    dut.pc, 32'd48);
    check("res_fs_pc", fs_es_o_pc, 32'd44);

    // asynchronous reset between edges
    d_i_MemtoReg = 1'b0;
    d_rst = 1'b0;
    #1;
    check("arst_pc",     dut.pc, 32'h0);
    check("arst_fs_pc",  fs_es_o_pc, 32'h0);
    check("arst_instr",  dut.fs_ds_o_instr, 32'h0);
    check("arst_opcode", {26'h0, ds_es_o_opcode}, 32'h0);
    check("arst_wb",     write_back_data, 32'h0);
    check("arst_rf6",    dut.rf[6], 32'h18);
    check("arst_dmem3",  dut.dmem[3], 32'hA000_0003);
    d_i_MemtoReg = 1'b1;
    #1;
    check("arst_wb_mem", write_back_data, 32'hA000_0000);
    d_i_MemRead = 1'b0;
    #1;
    check("arst_wb_nord", write_back_data, 32'h0);
    d_i_MemRead = 1'b1;

    // second run: freeze with lw held in the decode/execute boundary
    repeat (2) step();
    d_rst = 1'b1;
    repeat (2) step();
    d_i_ce = 1'b0;
    repeat (3) step();
    check("frz2_pc",     dut.pc, 32'h8);
    check("frz2_rs",     dut.ds_es_o_data_rs, 32'h1C);
    check("frz2_rt",     dut.ds_es_o_data_rt, 32'h18);
    check("frz2_opcode", {26'h0, ds_es_o_opcode}, 32'h23);
    check("frz2_alu",    dut.es_ms_alu_value, 32'h0);
    check("frz2_rf6",    dut.rf[6], 32'h18);
    d_i_ce = 1'b1;
    step();
    check("res2_alu", dut.es_ms_alu_value, 32'h30);
    check("res2_wb",  write_back_data, 32'hA000_000C);
    step();
    check("res2_rf6", dut.rf[6], 32'hA000_000C);
    check("res2_pc",  dut.pc, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
